gram_sdp_rd_stream: RTL and testbench

//  Read-side engine for a gram_sdp circular buffer. Tracks the writer's pointer and issues in-order

---
 rtl/gram_sdp_rd_stream.sv | 91 +++++++++
 tb/tb_gram_sdp_rd_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gram_sdp_rd_stream.sv
// Read-side streaming engine for a gram_sdp circular buffer: tracks the writer pointer,
// issues in-order RAM reads and presents the returning words on a valid/ready stream.
module gram_sdp_rd_stream #(
  parameter int BUS_SIZE_ADDR = 4,
  parameter int BUS_SIZE_DATA = 32,
  parameter int GRAM_MODE     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BUS_SIZE_ADDR:0]   wr_ptr,
  output logic [BUS_SIZE_ADDR:0]   rd_ptr,
  output logic [BUS_SIZE_ADDR-1:0] ram_raddr,
  input  logic [BUS_SIZE_DATA-1:0] ram_dout,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BUS_SIZE_DATA-1:0] out_data
);

  localparam int RD_LAT     = (GRAM_MODE == 0) ? 0 : ((GRAM_MODE == 3) ? 2 : 1);
  localparam int WR2RD      = (GRAM_MODE >= 2) ? 2 : 1;
  localparam int SKID_DEPTH = RD_LAT + 1;
  localparam int SR_W       = (RD_LAT > 0) ? RD_LAT : 1;
  localparam logic [3:0] SKID_D4 = 4'(SKID_DEPTH);
  localparam logic [2:0] SKID_D3 = 3'(SKID_DEPTH);
  localparam logic [BUS_SIZE_ADDR:0] PTR_ONE = 1;

  logic [BUS_SIZE_ADDR:0]   wr_ptr_p1;
  logic [BUS_SIZE_ADDR:0]   wr_eff;
  logic [SR_W-1:0]          vld_p;
  logic [2:0]               skid_cnt;
  logic [2:0]               inflight_cnt;
  logic [2:0]               wr_idx;
  logic [3:0]               occ;
  logic                     avail;
  logic                     pop;
  logic                     issue;
  logic                     push;
  logic [BUS_SIZE_DATA-1:0] skid_q [SKID_DEPTH];

  assign wr_eff    = (WR2RD == 2) ? wr_ptr_p1 : wr_ptr;
  assign avail     = (wr_eff != rd_ptr);
  assign pop       = out_valid & out_ready;
  assign ram_raddr = rd_ptr[BUS_SIZE_ADDR-1:0];

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) inflight_cnt = inflight_cnt + {2'b0, vld_p[i]};
  end

  // Credit counts words already buffered plus reads still travelling through the RAM.
  assign occ    = {1'b0, skid_cnt} + {1'b0, inflight_cnt} - {3'b0, pop};
  assign issue  = avail & ~flush & (occ < SKID_D4);
  assign push   = (RD_LAT == 0) ? issue : vld_p[SR_W-1];
  assign wr_idx = skid_cnt - {2'b0, pop};

  assign out_valid = (skid_cnt != 3'd0);
  assign out_data  = skid_q[0];

  // Stage p0: issue and pointer tracking; stages p1..pRD_LAT: outstanding-read valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr_p1 <= '0;
      vld_p     <= '0;
      skid_cnt  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_q[i] <= '0;
    end else begin
      wr_ptr_p1 <= wr_ptr;
      if (flush) begin
        rd_ptr   <= wr_ptr;
        vld_p    <= '0;
        skid_cnt <= '0;
      end else begin
        if (issue) rd_ptr <= rd_ptr + PTR_ONE;
        for (int i = SR_W - 1; i > 0; i--) vld_p[i] <= vld_p[i-1];
        vld_p[0] <= issue & (RD_LAT > 0);
        skid_cnt <= skid_cnt + {2'b0, push} - {2'b0, pop};
        // Skid stage: head lives at index 0; a pop shifts, a push lands behind the survivors.
        for (int i = 0; i < SKID_DEPTH; i++) begin
          if (push && (3'(i) == wr_idx)) skid_q[i] <= ram_dout;
          else if (pop && (i < SKID_DEPTH - 1)) skid_q[i] <= skid_q[(i < SKID_DEPTH - 1) ? i + 1 : i];
        end
      end
    end
  end

  skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && (skid_cnt == SKID_D3)));

endmodule

// File: tb/tb_gram_sdp_rd_stream.sv
// Bench for gram_sdp_rd_stream: three instances (mode 3/4-bit, mode 1/4-bit, mode 0/2-bit)
// each with a behavioural writer and RAM, checked by a shared in-order scoreboard.
module tb_gram_sdp_rd_stream;

  logic        clk;
  logic        rst;
  logic        we    [3];
  logic [31:0] wdata [3];
  logic        pub   [3];
  logic        rdy   [3];
  logic        fl    [3];
  logic        ov    [3];
  logic [31:0] od    [3];
  logic [4:0]  rp    [3];
  logic [3:0]  ra    [3];
  int          sel;
  int          checks;
  int          errors;
  logic [31:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : h
    localparam int AW   = (g == 2) ? 2 : 4;
    localparam int MODE = (g == 0) ? 3 : ((g == 1) ? 1 : 0);
    logic [AW:0]   wcnt;
    logic [AW:0]   wr_ptr_s;
    logic [AW:0]   rd_ptr_s;
    logic [AW-1:0] raddr;
    logic [31:0]   mem [2**AW];
    logic [31:0]   q1;
    logic [31:0]   q2;
    logic [31:0]   dout;
    logic          ov_s;
    logic [31:0]   od_s;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wcnt     <= '0;
        wr_ptr_s <= '0;
      end else begin
        if (pub[g]) wr_ptr_s <= wcnt;
        if (we[g]) wcnt <= wcnt + {{AW{1'b0}}, 1'b1};
      end
    end

    always_ff @(posedge clk) begin
      if (we[g]) mem[wcnt[AW-1:0]] <= wdata[g];
      q1 <= mem[raddr];
      q2 <= q1;
    end

    assign dout = (MODE == 0) ? mem[raddr] : ((MODE == 3) ? q2 : q1);

    gram_sdp_rd_stream #(
      .BUS_SIZE_ADDR(AW),
      .BUS_SIZE_DATA(32),
      .GRAM_MODE    (MODE)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .wr_ptr   (wr_ptr_s),
      .rd_ptr   (rd_ptr_s),
      .ram_raddr(raddr),
      .ram_dout (dout),
      .flush    (fl[g]),
      .out_valid(ov_s),
      .out_ready(rdy[g]),
      .out_data (od_s)
    );

    assign ov[g] = ov_s;
    assign od[g] = od_s;
    assign rp[g] = 5'(rd_ptr_s);
    assign ra[g] = 4'(raddr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int g, input logic [31:0] d);
    we[g]    = 1'b1;
    wdata[g] = d;
    exp_q.push_back(d);
    tick();
    we[g] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && ov[sel] && rdy[sel]) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_extra: observed word %0h, expected no word", od[sel]);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_data", od[sel], e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    sel    = 0;
    rst    = 1'b1;
    for (int g = 0; g < 3; g++) begin
      we[g] = 1'b0; wdata[g] = '0; pub[g] = 1'b1; rdy[g] = 1'b0; fl[g] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check("rst_ov", 32'(ov[g]), 32'd0);
      check("rst_rd_ptr", 32'(rp[g]), 32'd0);
      check("rst_data", od[g], 32'd0);
      check("rst_raddr", 32'(ra[g]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // T1: mode 3, four words published at once, full-rate drain
    sel = 0; rdy[0] = 1'b1; pub[0] = 1'b0;
    for (int k = 0; k < 4; k++) wr(0, 32'hA0 + k);
    pub[0] = 1'b1;
    tick();
    check("t1_ov_wait", 32'(ov[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_ov_wait", 32'(ov[0]), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_ov", 32'(ov[0]), 32'd1);
      check("t1_data", od[0], 32'hA0 + k);
    end
    tick();
    check("t1_ov_end", 32'(ov[0]), 32'd0);
    check("t1_rd_ptr", 32'(rp[0]), 32'd4);

    // T2: mode 1, eight words, stalled for five cycles
    sel = 1; rdy[1] = 1'b0; pub[1] = 1'b0;
    for (int k = 0; k < 8; k++) wr(1, 32'h100 + k);
    pub[1] = 1'b1;
    tick();
    repeat (4) tick();
    check("t2_rd_ptr_stall", 32'(rp[1]), 32'd2);
    check("t2_ov_stall", 32'(ov[1]), 32'd1);
    check("t2_data_hold", od[1], 32'h100);
    rdy[1] = 1'b1;
    drain("t2_drain");
    check("t2_rd_ptr", 32'(rp[1]), 32'd8);

    // T4: mode 0, three words, single-cycle latency, no bubbles
    sel = 2; rdy[2] = 1'b1; pub[2] = 1'b0;
    for (int k = 0; k < 3; k++) wr(2, 32'h200 + k);
    pub[2] = 1'b1;
    tick();
    check("t4_ov_issue", 32'(ov[2]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_ov", 32'(ov[2]), 32'd1);
      check("t4_data", od[2], 32'h200 + k);
    end
    tick();
    check("t4_ov_end", 32'(ov[2]), 32'd0);
    check("t4_rd_ptr", 32'(rp[2]), 32'd3);

    // T3: 4-deep buffer, fill to full across the wrap, then stream the rest
    rdy[2] = 1'b0;
    for (int k = 0; k < 5; k++) wr(2, 32'h300 + k);
    repeat (3) tick();
    check("t3_rd_ptr_wrap", 32'(rp[2]), 32'd4);
    check("t3_raddr", 32'(ra[2]), 32'd0);
    check("t3_ov_full", 32'(ov[2]), 32'd1);
    check("t3_data_full", od[2], 32'h300);
    rdy[2] = 1'b1;
    drain("t3_drain_full");
    check("t3_rd_ptr_mid", 32'(rp[2]), 32'd0);
    for (int k = 5; k < 10; k++) wr(2, 32'h300 + k);
    drain("t3_drain_stream");
    check("t3_rd_ptr_end", 32'(rp[2]), 32'd5);

    // T5: mode 3, flush with two reads in flight and one word buffered
    sel = 0; rdy[0] = 1'b0; pub[0] = 1'b0;
    for (int k = 0; k < 4; k++) wr(0, 32'hC0 + k);
    pub[0] = 1'b1;
    tick();
    repeat (4) tick();
    check("t5_rd_ptr_pre", 32'(rp[0]), 32'd7);
    check("t5_ov_pre", 32'(ov[0]), 32'd1);
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    rdy[0] = 1'b1;
    exp_q.delete();
    check("t5_ov_flush", 32'(ov[0]), 32'd0);
    check("t5_rd_ptr_flush", 32'(rp[0]), 32'd8);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_ov_stale", 32'(ov[0]), 32'd0);
    end
    wr(0, 32'h55);
    drain("t5_drain");
    check("t5_rd_ptr_end", 32'(rp[0]), 32'd9);

    // T6: asynchronous reset between clock edges while streaming
    for (int k = 0; k < 6; k++) wr(0, 32'h60 + k);
    tick();
    check("t6_ov_pre", 32'(ov[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_ov_async", 32'(ov[0]), 32'd0);
    check("t6_rd_ptr_async", 32'(rp[0]), 32'd0);
    check("t6_data_async", od[0], 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    wr(0, 32'h77);
    wr(0, 32'h78);
    drain("t6_drain");
    check("t6_rd_ptr_end", 32'(rp[0]), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
